// File: rtl/rr_request_queue.sv
// Per-client request FIFOs feeding a round-robin arbiter, with a single output register
// drained by the consumer through a valid/ready handshake.
module rr_request_queue #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           push_valid,
  input  logic [N_REQ*DATA_W-1:0]    push_data,
  output logic [N_REQ-1:0]           push_ready,
  output logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           grant,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  input  logic                       out_ready,
  output logic                       grant_err
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [N_REQ][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [N_REQ];
  logic [PTR_W-1:0]  rd_ptr [N_REQ];
  logic [CNT_W-1:0]  cnt    [N_REQ];

  logic [N_REQ-1:0] full;
  logic [N_REQ-1:0] empty;
  logic [N_REQ-1:0] push_en;
  logic [N_REQ-1:0] vgrant;
  logic [N_REQ-1:0] pop;
  logic             slot_free;
  logic             pop_any;
  logic [SRC_W-1:0] sel;
  logic             illegal;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < N_REQ; i++) begin
      full[i]  = (cnt[i] == CNT_W'(DEPTH));
      empty[i] = (cnt[i] == '0);
    end
  end

  assign slot_free  = !out_valid || out_ready;
  assign push_ready = ~full;
  assign req        = ~empty & {N_REQ{slot_free}};
  assign push_en    = push_valid & ~full;
  assign vgrant     = grant & req;

  // A multi-bit grant is tolerated by honouring only its lowest requesting bit.
  always_comb begin
    pop     = '0;
    sel     = '0;
    pop_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vgrant[i] && !pop_any) begin
        pop[i]  = 1'b1;
        sel     = SRC_W'(i);
        pop_any = 1'b1;
      end
    end
  end

  assign illegal = ($countones(grant) > 1) || (|(grant & ~req));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CNT_W'(push_en[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Storage carries no reset; the counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (push_en[i]) mem[i][wr_ptr[i]] <= push_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      grant_err <= 1'b0;
    end else begin
      if (pop_any) begin
        out_valid <= 1'b1;
        out_data  <= mem[sel][rd_ptr[sel]];
        out_src   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (illegal) grant_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_request_queue.sv
// Scoreboard bench for rr_request_queue: directed scenarios plus randomized traffic against
// a queue-based reference model; a separate monitor checks every presented output word.
module tb_rr_request_queue;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  push_valid = '0;
  logic [N*W-1:0] push_data = '0;
  logic [N-1:0]  push_ready;
  logic [N-1:0]  req;
  logic [N-1:0]  grant = '0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_src;
  logic          out_ready = 1'b0;
  logic          grant_err;

  rr_request_queue #(.N_REQ(N), .DATA_W(W), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .req(req), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: one queue per client, output slot occupancy, sticky error
  logic [7:0] mq [N][$];
  logic [9:0] exp_q [$];
  bit         m_out  = 1'b0;
  bit         m_gerr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_req(input logic ordy);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0) && (!m_out || ordy);
    return r;
  endfunction

  // Applies one cycle of stimulus starting just after a rising edge; returns just after the next.
  task automatic step(input logic [N-1:0] pv, input logic [N*W-1:0] pd,
                      input logic [N-1:0] g, input logic ordy);
    logic [N-1:0] e_req;
    logic [N-1:0] e_pr;
    logic [N-1:0] vg;
    logic [7:0]   head;
    bit           done;
    push_valid = pv;
    push_data  = pd;
    grant      = g;
    out_ready  = ordy;
    @(negedge clk);
    e_req = model_req(ordy);
    for (int i = 0; i < N; i++) e_pr[i] = (mq[i].size() < D);
    chk("req", req, e_req);
    chk("push_ready", push_ready, e_pr);
    chk("out_valid", out_valid, m_out);
    chk("grant_err", grant_err, m_gerr);
    vg   = g & e_req;
    done = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vg[i] && !done) begin
        head = mq[i].pop_front();
        exp_q.push_back({2'(i), head});
        done = 1'b1;
      end
    end
    for (int i = 0; i < N; i++)
      if (pv[i] && e_pr[i]) mq[i].push_back(pd[i*W +: W]);
    if ($countones(g) > 1 || (g & ~e_req) != '0) m_gerr = 1'b1;
    if (done)      m_out = 1'b1;
    else if (ordy) m_out = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    push_valid = N'($urandom);
    push_data  = $urandom;
    grant      = N'($urandom);
    out_ready  = 1'($urandom);
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_q.delete();
    m_out  = 1'b0;
    m_gerr = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req", req, 0);
    chk("rst_push_ready", push_ready, 4'hF);
    chk("rst_grant_err", grant_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    @(posedge clk);
    #1;
    push_valid = '0;
    grant      = '0;
    out_ready  = 1'b0;
    reset_n    = 1'b1;
  endtask

  // monitor: every word the DUT presents must match the scoreboard head
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_word: unexpected word src=%0d data=%0h at %0t", out_src, out_data, $time);
      end else begin
        chk("out_word", {out_src, out_data}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [N-1:0] pick_grant(input logic [N-1:0] r);
    logic [N-1:0] g;
    int start;
    int k;
    g = '0;
    start = int'($urandom_range(N - 1));
    for (int j = 0; j < N; j++) begin
      k = (start + j) % N;
      if (r[k] && g == '0) g[k] = 1'b1;
    end
    return g;
  endfunction

  initial begin
    logic [N-1:0] g;
    logic         ordy;
    int           rsel;
    int           guard;

    do_reset();

    // single push/pop through q2
    step(4'b0100, 32'h00A50000, 4'b0000, 1'b1);
    chk("s2_req_after_push", req, 4'b0100);
    step(4'b0000, 32'h0, 4'b0100, 1'b1);
    chk("s2_out_valid", out_valid, 1);
    chk("s2_out_data", out_data, 8'hA5);
    chk("s2_out_src", out_src, 2);
    chk("s2_req_after_pop", req, 4'b0000);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);

    // fill q0, refuse a fifth push, drain in order
    for (int k = 0; k < D; k++) step(4'b0001, 32'(8'h20 + k), 4'b0000, 1'b0);
    chk("s3_full", push_ready, 4'b1110);
    step(4'b0001, 32'h000000EE, 4'b0000, 1'b0);
    chk("s3_still_full", push_ready, 4'b1110);
    for (int k = 0; k < D; k++) begin
      step(4'b0000, 32'h0, 4'b0001, 1'b1);
      chk("s3_drain_data", out_data, 8'h20 + k);
    end
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("s3_empty", push_ready, 4'b1111);

    // back-pressure, grant with no request
    step(4'b1010, 32'h3B001B00, 4'b0000, 1'b0);
    step(4'b0000, 32'h0, 4'b0010, 1'b0);
    chk("s4_first_word", out_data, 8'h1B);
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    chk("s4_req_blocked", req, 4'b0000);
    step(4'b0000, 32'h0, 4'b1000, 1'b0);
    chk("s4_grant_err", grant_err, 1);
    chk("s4_hold_data", out_data, 8'h1B);
    chk("s4_hold_src", out_src, 1);
    chk("s4_hold_valid", out_valid, 1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    step(4'b0000, 32'h0, 4'b1000, 1'b1);
    chk("s4_q3_data", out_data, 8'h3B);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    do_reset();

    // streaming, one word per cycle
    step(4'b1111, 32'h13121110, 4'b0000, 1'b1);
    for (int k = 0; k < N; k++) begin
      step(4'b0000, 32'h0, 4'(1 << k), 1'b1);
      chk("s5_valid", out_valid, 1);
      chk("s5_src", out_src, k);
      chk("s5_data", out_data, 8'h10 + k);
    end
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("s5_drained", out_valid, 0);

    // multi-bit grant honours lowest requester, error is sticky
    step(4'b0110, 32'h00262500, 4'b0000, 1'b1);
    step(4'b0000, 32'h0, 4'b0110, 1'b1);
    chk("s6_src", out_src, 1);
    chk("s6_data", out_data, 8'h25);
    chk("s6_err", grant_err, 1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("s6_err_sticky", grant_err, 1);
    step(4'b0000, 32'h0, 4'b0100, 1'b1);
    chk("s6_q2_data", out_data, 8'h26);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    do_reset();
    chk("s6_err_cleared", grant_err, 0);

    // randomized traffic with periodic mid-operation resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) begin
        do_reset();
      end else begin
        ordy = ($urandom_range(3) != 0);
        rsel = int'($urandom_range(99));
        if (rsel < 80)      g = pick_grant(model_req(ordy));
        else if (rsel < 95) g = '0;
        else                g = N'($urandom);
        step(N'($urandom), $urandom, g, ordy);
      end
    end

    // drain everything that is left
    guard = 0;
    while (guard < 64 && (m_out || mq[0].size() != 0 || mq[1].size() != 0 ||
                          mq[2].size() != 0 || mq[3].size() != 0)) begin
      step(4'b0000, 32'h0, pick_grant(model_req(1'b1)), 1'b1);
      guard++;
    end
    chk("drain_bounded", guard < 64, 1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("drain_scoreboard_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
